// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer: FSM state
// encoding, accumulator sizing and signed saturation.
package fc_pkg;

  // Controller states. IDLE waits for start, MAC walks every
  // (neuron, element) pair one product per cycle, DONE pulses completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } fc_state_t;

  // Width of the wide intermediate handed to saturate().
  localparam int SAT_W = 64;

  // Accumulator width that holds the sum of n full-width products
  // without overflow.
  function automatic int acc_width(input int width, input int n);
    return 2 * width + $clog2(n);
  endfunction

  // Clamp a wide signed value into the signed range of a width-bit word.
  // The caller keeps the low width bits of the result.
  function automatic logic signed [SAT_W-1:0] saturate(
    input logic signed [SAT_W-1:0] v,
    input int                      width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/fc_mac.sv
// Time-shared signed multiply-accumulate for one output neuron at a time.
// The accumulator keeps full precision; on the last element of a neuron the
// combinational result adds the current product and the scaled bias,
// rescales by an arithmetic right shift (truncation toward -inf) and
// saturates to WIDTH bits. The accumulator clears itself on that same edge
// so the next neuron starts from zero.
module fc_mac
  import fc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int N     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic                    last,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] w,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] result
);

  localparam int ACC_W = acc_width(WIDTH, N);
  // One guard bit above the accumulator so adding the final product and
  // the shifted bias can never wrap.
  localparam int SUM_W = ACC_W + 1;

  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [SUM_W-1:0]   sum;
  logic signed [SUM_W-1:0]   shifted;

  // Full-width product, final sum with bias in the product's Q format,
  // rescale and saturate.
  always_comb begin
    prod    = (2*WIDTH)'(x) * (2*WIDTH)'(w);
    sum     = SUM_W'(acc) + SUM_W'(prod) + (SUM_W'(b) <<< FRAC);
    shifted = sum >>> FRAC;
    result  = WIDTH'(saturate(SAT_W'(shifted), WIDTH));
  end

  // Accumulator: cleared at run start and after each neuron's last product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      if (last) begin
        acc <= '0;
      end else begin
        acc <= acc + ACC_W'(prod);
      end
    end
  end

endmodule

// File: rtl/fc_layer.sv
// Sequential fully-connected layer. On start (in IDLE) the pooled map,
// weights and biases are snapshotted, the map is flattened row-major
// (j = r*INPUT_DIM_WIDTH + c) and every neuron is evaluated with a single
// multiply-accumulate unit, one product per cycle. Each output_vector
// entry is written when its neuron's last product is consumed and holds
// until overwritten by the next run.
//
// Handshake: start is a level sampled only in IDLE; a high start on the
// IDLE edge launches a run and is ignored in every other state (no
// queuing). busy is high for exactly the N*OUTPUT_SIZE MAC cycles, and done
// is a one-cycle pulse in the following cycle, while busy is low.
module fc_layer
  import fc_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int FRAC             = 8,
  parameter int INPUT_DIM_HEIGHT = 2,
  parameter int INPUT_DIM_WIDTH  = 2,
  parameter int OUTPUT_SIZE      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] input_feature_map [0:INPUT_DIM_HEIGHT-1][0:INPUT_DIM_WIDTH-1],
  input  logic signed [WIDTH-1:0] weights [0:OUTPUT_SIZE-1][0:INPUT_DIM_HEIGHT*INPUT_DIM_WIDTH-1],
  input  logic signed [WIDTH-1:0] bias [0:OUTPUT_SIZE-1],
  output logic signed [WIDTH-1:0] output_vector [0:OUTPUT_SIZE-1],
  output logic                    busy,
  output logic                    done
);

  localparam int N  = INPUT_DIM_HEIGHT * INPUT_DIM_WIDTH;
  localparam int JW = (N > 1) ? $clog2(N) : 1;
  localparam int IW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N - 1);
  localparam logic [IW-1:0] I_LAST = IW'(OUTPUT_SIZE - 1);

  fc_state_t state;
  logic [JW-1:0] j_cnt;
  logic [IW-1:0] i_cnt;

  // Snapshot of the operands, so upstream may change them after launch.
  logic signed [WIDTH-1:0] x_q [0:N-1];
  logic signed [WIDTH-1:0] w_q [0:OUTPUT_SIZE-1][0:N-1];
  logic signed [WIDTH-1:0] b_q [0:OUTPUT_SIZE-1];

  logic                    launch;
  logic                    mac_en;
  logic                    mac_last;
  logic signed [WIDTH-1:0] mac_result;

  // Status outputs and MAC controls follow the registered state directly.
  always_comb begin
    launch   = (state == IDLE) && start;
    mac_en   = (state == MAC);
    mac_last = (j_cnt == J_LAST);
    busy     = (state == MAC);
    done     = (state == DONE);
  end

  // Capture registers: snapshot and flatten the operands on launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        x_q[k] <= '0;
      end
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        b_q[i] <= '0;
        for (int k = 0; k < N; k++) begin
          w_q[i][k] <= '0;
        end
      end
    end else if (launch) begin
      for (int r = 0; r < INPUT_DIM_HEIGHT; r++) begin
        for (int c = 0; c < INPUT_DIM_WIDTH; c++) begin
          x_q[r*INPUT_DIM_WIDTH + c] <= input_feature_map[r][c];
        end
      end
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        b_q[i] <= bias[i];
        for (int k = 0; k < N; k++) begin
          w_q[i][k] <= weights[i][k];
        end
      end
    end
  end

  // FSM and (neuron, element) counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      i_cnt <= '0;
      j_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            i_cnt <= '0;
            j_cnt <= '0;
          end
        end
        MAC: begin
          if (j_cnt == J_LAST) begin
            j_cnt <= '0;
            if (i_cnt == I_LAST) begin
              i_cnt <= '0;
              state <= DONE;
            end else begin
              i_cnt <= i_cnt + IW'(1);
            end
          end else begin
            j_cnt <= j_cnt + JW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Result registers: each neuron's entry is written on its last product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTPUT_SIZE; i++) begin
        output_vector[i] <= '0;
      end
    end else if (mac_en && mac_last) begin
      output_vector[i_cnt] <= mac_result;
    end
  end

  fc_mac #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .N     (N)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (launch),
    .en     (mac_en),
    .last   (mac_last),
    .x      (x_q[j_cnt]),
    .w      (w_q[i_cnt][j_cnt]),
    .b      (b_q[i_cnt]),
    .result (mac_result)
  );

endmodule

// File: tb/tb_fc_layer.sv
// Directed bench for fc_layer with the default 2x2 map and two neurons.
module tb_fc_layer;

  localparam int WIDTH    = 16;
  localparam int FRAC     = 8;
  localparam int H        = 2;
  localparam int WD       = 2;
  localparam int OS       = 2;
  localparam int N        = H * WD;
  localparam int RUN_WIN  = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  always #5 clk = ~clk;

  logic signed [WIDTH-1:0] ifm  [0:H-1][0:WD-1];
  logic signed [WIDTH-1:0] wts  [0:OS-1][0:N-1];
  logic signed [WIDTH-1:0] bia  [0:OS-1];
  logic signed [WIDTH-1:0] outv [0:OS-1];
  logic busy;
  logic done;

  fc_layer #(
    .WIDTH            (WIDTH),
    .FRAC             (FRAC),
    .INPUT_DIM_HEIGHT (H),
    .INPUT_DIM_WIDTH  (WD),
    .OUTPUT_SIZE      (OS)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .input_feature_map (ifm),
    .weights           (wts),
    .bias              (bia),
    .output_vector     (outv),
    .busy              (busy),
    .done              (done)
  );

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_t;
  int lat, busy_cyc, done_cnt, extra, done_seen;
  logic [WIDTH-1:0] mid0, mid1;

  task automatic check_w(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_n(input string tag, input int obs, input int exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_uniform(input logic signed [WIDTH-1:0] xv,
                             input logic signed [WIDTH-1:0] w0v,
                             input logic signed [WIDTH-1:0] b0v,
                             input logic signed [WIDTH-1:0] w1v,
                             input logic signed [WIDTH-1:0] b1v);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < WD; c++)
        ifm[r][c] = xv;
    for (int j = 0; j < N; j++) begin
      wts[0][j] = w0v;
      wts[1][j] = w1v;
    end
    bia[0] = b0v;
    bia[1] = b1v;
  endtask

  // One start pulse, then observe a bounded window. k=0 is the cycle right
  // after the launch edge E0. With disturb set, the map is overwritten and
  // start is pulsed again one cycle after E0.
  task automatic do_run(input bit disturb, output int lat_o, output int busy_o,
                        output int done_o, output logic [WIDTH-1:0] m0,
                        output logic [WIDTH-1:0] m1);
    lat_o = -1; busy_o = 0; done_o = 0; m0 = 'x; m1 = 'x;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < RUN_WIN; k++) begin
      if (disturb && k == 0) begin
        for (int r = 0; r < H; r++)
          for (int c = 0; c < WD; c++)
            ifm[r][c] = 16'sd512;
        start = 1'b1;
      end
      if (disturb && k == 1) start = 1'b0;
      if (busy) busy_o++;
      if (done) begin
        done_o++;
        if (lat_o < 0) lat_o = k;
      end
      if (k == N) begin
        m0 = outv[0];
        m1 = outv[1];
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    set_uniform(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    repeat (3) @(negedge clk);
    check_w("reset_out0", outv[0], 16'h0000);
    check_w("reset_out1", outv[1], 16'h0000);
    check_n("reset_busy", int'(busy), 0);
    check_n("reset_done", int'(done), 0);
    rst_n = 1'b1;

    // 1.0 inputs: row0 weights 1.0 -> 4.0; row1 weights -0.5, bias 1.0 -> -1.0
    set_uniform(16'sd256, 16'sd256, 16'sd0, -16'sd128, 16'sd256);
    do_run(1'b0, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("basic_out0", outv[0], 16'h0400);
    check_w("basic_out1", outv[1], 16'hFF00);
    check_n("basic_done_latency", lat, 8);
    check_n("basic_busy_cycles", busy_cyc, 8);
    check_n("basic_done_count", done_cnt, 1);
    check_w("basic_mid_out0", mid0, 16'h0400);
    check_w("basic_mid_out1", mid1, 16'h0000);

    // positive saturation on both neurons
    set_uniform(16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sh7FFF, 16'sd0);
    do_run(1'b0, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("satpos_out0", outv[0], 16'h7FFF);
    check_w("satpos_out1", outv[1], 16'h7FFF);

    // negative saturation on neuron 1
    set_uniform(16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sh8000, 16'sd0);
    do_run(1'b0, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("satneg_out0", outv[0], 16'h7FFF);
    check_w("satneg_out1", outv[1], 16'h8000);

    // truncation toward -inf: 1*128 >>> 8 = 0, -1*128 >>> 8 = -1
    set_uniform(16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
    ifm[0][0] = 16'sd1;
    wts[0][0] = 16'sd128;
    do_run(1'b0, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("trunc_pos_out0", outv[0], 16'h0000);
    check_w("trunc_pos_out1", outv[1], 16'h0000);
    ifm[0][0] = -16'sd1;
    do_run(1'b0, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("trunc_neg_out0", outv[0], 16'hFFFF);

    // snapshot: map changed and start re-pulsed one cycle after launch
    set_uniform(16'sd256, 16'sd256, 16'sd0, -16'sd128, 16'sd256);
    do_run(1'b1, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("snap_out0", outv[0], 16'h0400);
    check_w("snap_out1", outv[1], 16'hFF00);
    check_n("snap_done_latency", lat, 8);
    check_n("snap_done_count", done_cnt, 1);

    // asynchronous reset just after edge E3 of a run
    set_uniform(16'sd256, 16'sd256, 16'sd0, -16'sd128, 16'sd256);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_w("midrst_out0", outv[0], 16'h0000);
    check_w("midrst_out1", outv[1], 16'h0000);
    check_n("midrst_busy", int'(busy), 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_n("midrst_no_done_or_busy", done_seen, 0);

    // restart after reset: 4*1.0*2.0 - 1.0 = 7.0 ; 4*1.0*0.25 = 1.0
    set_uniform(16'sd256, 16'sd512, -16'sd256, 16'sd64, 16'sd0);
    do_run(1'b0, lat, busy_cyc, done_cnt, mid0, mid1);
    check_w("restart_out0", outv[0], 16'h0700);
    check_w("restart_out1", outv[1], 16'h0100);
    check_n("restart_done_latency", lat, 8);

    // back-to-back: start held high, runs every N*OS+2 = 10 cycles
    set_uniform(16'sd256, 16'sd256, 16'sd0, -16'sd128, 16'sd256);
    exp_q.delete();
    for (int p = 0; p < 4; p++) exp_q.push_back(WIDTH'(8 + p * 10));
    extra = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        if (exp_q.size() == 0) begin
          extra++;
        end else begin
          exp_t = exp_q.pop_front();
          check_w("b2b_done_cycle", WIDTH'(k), exp_t);
        end
      end
    end
    start = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) extra++;
    end
    check_n("b2b_missing_done", exp_q.size(), 0);
    check_n("b2b_extra_done", extra, 0);
    check_w("b2b_out0", outv[0], 16'h0400);
    check_w("b2b_out1", outv[1], 16'hFF00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
